// File: rtl/tag_system_engine.sv
// tag_system_engine
//   Hardware tag-system interpreter. Each step reads the head symbol H of a
//   circular-buffer queue, deletes M symbols from the head, and appends the
//   production programmed for H (one symbol per cycle). A run ends on a step
//   limit, a word shorter than M, the halting symbol, or a would-be overflow.
//
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   cfg_we/sym/len/word  production table write (accepted in IDLE only)
//   ld_valid/ld_sym/ld_ready  initial word load (IDLE only)
//   start, clear    begin a run / empty queue and return to IDLE
//   max_steps       step limit (0 = unlimited)
//   rd_en, rd_sym   pop head in DONE / show-ahead head symbol
//   busy, done      READ|APPEND / DONE
//   reason          0 none, 1 halt, 2 short word, 3 overflow, 4 step limit
//   step_count      committed steps (saturating)
//   q_count         queue occupancy
module tag_system_engine #(
  parameter int unsigned SYM_W    = 2,
  parameter int unsigned DEPTH    = 32,
  parameter int unsigned M        = 2,
  parameter int unsigned PLEN     = 4,
  parameter int unsigned HALT_SYM = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cfg_we,
  input  logic [SYM_W-1:0]             cfg_sym,
  input  logic [$clog2(PLEN+1)-1:0]    cfg_len,
  input  logic [PLEN*SYM_W-1:0]        cfg_word,
  input  logic                         ld_valid,
  input  logic [SYM_W-1:0]             ld_sym,
  output logic                         ld_ready,
  input  logic                         start,
  input  logic                         clear,
  input  logic [15:0]                  max_steps,
  input  logic                         rd_en,
  output logic [SYM_W-1:0]             rd_sym,
  output logic                         busy,
  output logic                         done,
  output logic [2:0]                   reason,
  output logic [15:0]                  step_count,
  output logic [$clog2(DEPTH+1)-1:0]   q_count
);

  localparam int unsigned LW   = $clog2(PLEN+1);
  localparam int unsigned QW   = $clog2(DEPTH+1);
  localparam int unsigned PW   = $clog2(DEPTH);
  localparam int unsigned AW   = $clog2(DEPTH+PLEN+1);
  localparam int unsigned NSYM = 1 << SYM_W;

  localparam logic [2:0] RS_HALT  = 3'd1;
  localparam logic [2:0] RS_SHORT = 3'd2;
  localparam logic [2:0] RS_OVFL  = 3'd3;
  localparam logic [2:0] RS_STEPS = 3'd4;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_APPEND, S_DONE} state_t;

  state_t                 r_state, w_state_nxt;
  logic [PW-1:0]          r_rd_ptr, r_wr_ptr;
  logic [QW-1:0]          r_q_count;
  logic [15:0]            r_step_count;
  logic [2:0]             r_reason;
  logic [LW-1:0]          r_len  [NSYM];
  logic [PLEN*SYM_W-1:0]  r_word [NSYM];
  logic [SYM_W-1:0]       r_mem  [DEPTH];
  logic [PLEN*SYM_W-1:0]  r_prod;
  logic [LW-1:0]          r_plen;
  logic [LW-1:0]          r_k;

  logic                   w_push;
  logic                   w_term;
  logic [2:0]             w_term_code;
  logic                   w_step;
  logic [LW-1:0]          w_len;
  logic [AW-1:0]          w_need;
  logic [LW-1:0]          w_k_next;
  logic                   w_last;
  logic [SYM_W-1:0]       w_app_sym;
  logic                   w_mem_we;
  logic [SYM_W-1:0]       w_mem_din;

  assign rd_sym     = r_mem[r_rd_ptr];
  assign busy       = (r_state == S_READ) || (r_state == S_APPEND);
  assign done       = (r_state == S_DONE);
  assign reason     = r_reason;
  assign step_count = r_step_count;
  assign q_count    = r_q_count;
  assign ld_ready   = (r_state == S_IDLE) && (r_q_count < QW'(DEPTH));

  assign w_push   = ld_valid && ld_ready && !clear;
  assign w_len    = r_len[rd_sym];
  // Widened so occupancy plus a full production never wraps.
  assign w_need   = AW'(r_q_count) - AW'(M) + AW'(w_len);
  assign w_k_next = r_k + LW'(1);
  assign w_last   = (w_k_next == r_plen);

  always_comb begin
    w_app_sym = '0;
    for (int unsigned k = 0; k < PLEN; k++) begin
      if (r_k == LW'(k)) w_app_sym = r_prod[k*SYM_W +: SYM_W];
    end
  end

  assign w_mem_we  = w_push || ((r_state == S_APPEND) && !clear);
  assign w_mem_din = (r_state == S_APPEND) ? w_app_sym : ld_sym;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_term      = 1'b0;
    w_term_code = '0;
    w_step      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!clear && start) w_state_nxt = S_READ;
      end
      S_READ: begin
        if (clear) begin
          w_state_nxt = S_IDLE;
        end else if ((max_steps != 16'd0) && (r_step_count == max_steps)) begin
          w_term = 1'b1; w_term_code = RS_STEPS;
        end else if (r_q_count < QW'(M)) begin
          w_term = 1'b1; w_term_code = RS_SHORT;
        end else if (rd_sym == SYM_W'(HALT_SYM)) begin
          w_term = 1'b1; w_term_code = RS_HALT;
        end else if (w_need > AW'(DEPTH)) begin
          w_term = 1'b1; w_term_code = RS_OVFL;
        end else begin
          w_step      = 1'b1;
          w_state_nxt = (w_len != '0) ? S_APPEND : S_READ;
        end
        if (w_term) w_state_nxt = S_DONE;
      end
      S_APPEND: begin
        if (clear)       w_state_nxt = S_IDLE;
        else if (w_last) w_state_nxt = S_READ;
      end
      S_DONE: begin
        if (clear) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_ptr     <= '0;
      r_wr_ptr     <= '0;
      r_q_count    <= '0;
      r_step_count <= '0;
      r_reason     <= '0;
      r_prod       <= '0;
      r_plen       <= '0;
      r_k          <= '0;
    end else if (clear) begin
      r_rd_ptr  <= '0;
      r_wr_ptr  <= '0;
      r_q_count <= '0;
      r_reason  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_step_count <= '0;
            r_reason     <= '0;
          end
          if (w_push) begin
            r_wr_ptr  <= r_wr_ptr + PW'(1);
            r_q_count <= r_q_count + QW'(1);
          end
        end
        S_READ: begin
          if (w_term) begin
            r_reason <= w_term_code;
          end else if (w_step) begin
            r_rd_ptr  <= r_rd_ptr + PW'(M);
            r_q_count <= r_q_count - QW'(M);
            if (r_step_count != 16'hFFFF) r_step_count <= r_step_count + 16'd1;
            r_prod <= r_word[rd_sym];
            r_plen <= w_len;
            r_k    <= '0;
          end
        end
        S_APPEND: begin
          r_wr_ptr  <= r_wr_ptr + PW'(1);
          r_q_count <= r_q_count + QW'(1);
          r_k       <= w_k_next;
        end
        S_DONE: begin
          if (rd_en && (r_q_count != '0)) begin
            r_rd_ptr  <= r_rd_ptr + PW'(1);
            r_q_count <= r_q_count - QW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NSYM; i++) r_len[i] <= '0;
    end else if (cfg_we && (r_state == S_IDLE)) begin
      r_len[cfg_sym] <= cfg_len;
    end
  end

  always_ff @(posedge clk) begin
    if (cfg_we && (r_state == S_IDLE)) r_word[cfg_sym] <= cfg_word;
  end

  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[r_wr_ptr] <= w_mem_din;
  end

endmodule

// File: tb/tb_tag_system_engine.sv
// Directed, table-driven bench for tag_system_engine. Two instances share all
// inputs: a default DEPTH=32 one and a DEPTH=4 one for overflow and wrap
// cases; use4 selects which instance's outputs are compared.
module tb_tag_system_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_we;
  logic [1:0]  cfg_sym;
  logic [2:0]  cfg_len;
  logic [7:0]  cfg_word;
  logic        ld_valid;
  logic [1:0]  ld_sym;
  logic        start, clear, rd_en;
  logic [15:0] max_steps;

  logic        ldr32, busy32, done32;
  logic [1:0]  rds32;
  logic [2:0]  rsn32;
  logic [15:0] stp32;
  logic [5:0]  q32;

  logic        ldr4, busy4, done4;
  logic [1:0]  rds4;
  logic [2:0]  rsn4;
  logic [15:0] stp4;
  logic [2:0]  q4;

  logic        use4;
  logic        s_ldr, s_busy, s_done;
  logic [1:0]  s_rds;
  logic [2:0]  s_rsn;
  logic [15:0] s_stp;
  logic [5:0]  s_q;

  assign s_ldr  = use4 ? ldr4  : ldr32;
  assign s_busy = use4 ? busy4 : busy32;
  assign s_done = use4 ? done4 : done32;
  assign s_rds  = use4 ? rds4  : rds32;
  assign s_rsn  = use4 ? rsn4  : rsn32;
  assign s_stp  = use4 ? stp4  : stp32;
  assign s_q    = use4 ? {3'b000, q4} : q32;

  tag_system_engine dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_sym(cfg_sym), .cfg_len(cfg_len),
    .cfg_word(cfg_word), .ld_valid(ld_valid), .ld_sym(ld_sym), .ld_ready(ldr32),
    .start(start), .clear(clear), .max_steps(max_steps), .rd_en(rd_en),
    .rd_sym(rds32), .busy(busy32), .done(done32), .reason(rsn32),
    .step_count(stp32), .q_count(q32)
  );

  tag_system_engine #(.DEPTH(4)) dut4 (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_sym(cfg_sym), .cfg_len(cfg_len),
    .cfg_word(cfg_word), .ld_valid(ld_valid), .ld_sym(ld_sym), .ld_ready(ldr4),
    .start(start), .clear(clear), .max_steps(max_steps), .rd_en(rd_en),
    .rd_sym(rds4), .busy(busy4), .done(done4), .reason(rsn4),
    .step_count(stp4), .q_count(q4)
  );

  always #5 clk = ~clk;

  // Symbol k of ld / dr sits at bits [2k +: 2]; k=0 is pushed / drained first.
  typedef struct packed {
    logic        use4;
    logic [2:0]  nld;
    logic [7:0]  ld;
    logic [15:0] maxs;
    logic [7:0]  cyc;
    logic [2:0]  reason;
    logic [15:0] steps;
    logic [5:0]  q;
    logic [2:0]  ndr;
    logic [9:0]  dr;
  } vec_t;

  localparam int NVEC = 9;
  vec_t vecs [NVEC];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic program_table;
    cfg_we = 1'b1;
    cfg_sym = 2'd1; cfg_len = 3'd2; cfg_word = 8'h0E; tick;  // 1 -> 2 3
    cfg_sym = 2'd2; cfg_len = 3'd1; cfg_word = 8'h01; tick;  // 2 -> 1
    cfg_sym = 2'd3; cfg_len = 3'd3; cfg_word = 8'h15; tick;  // 3 -> 1 1 1
    cfg_we = 1'b0;
  endtask

  task automatic load_and_start(input vec_t v);
    use4 = v.use4;
    max_steps = v.maxs;
    clear = 1'b1; tick; clear = 1'b0;
    for (int k = 0; k < int'(v.nld); k++) begin
      ld_valid = 1'b1;
      ld_sym   = v.ld[2*k +: 2];
      tick;
    end
    ld_valid = 1'b0;
    start = 1'b1; tick; start = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int id);
    int cyc;
    load_and_start(v);
    cyc = 0;
    while (s_busy && cyc < 300) begin
      cyc++;
      tick;
    end
    check($sformatf("v%0d_busy_cycles", id), cyc, int'(v.cyc));
    check($sformatf("v%0d_done", id), int'(s_done), 1);
    check($sformatf("v%0d_reason", id), int'(s_rsn), int'(v.reason));
    check($sformatf("v%0d_steps", id), int'(s_stp), int'(v.steps));
    check($sformatf("v%0d_qcount", id), int'(s_q), int'(v.q));
    for (int k = 0; k < int'(v.ndr); k++) begin
      check($sformatf("v%0d_drain%0d", id, k), int'(s_rds), int'(v.dr[2*k +: 2]));
      rd_en = 1'b1; tick; rd_en = 1'b0;
    end
    check($sformatf("v%0d_q_after_drain", id), int'(s_q), 0);
    rd_en = 1'b1; tick; rd_en = 1'b0;
    check($sformatf("v%0d_pop_empty_ignored", id), int'(s_q), 0);
  endtask

  initial begin
    rst = 1'b1; cfg_we = 1'b0; cfg_sym = '0; cfg_len = '0; cfg_word = '0;
    ld_valid = 1'b0; ld_sym = '0; start = 1'b0; clear = 1'b0; rd_en = 1'b0;
    max_steps = '0; use4 = 1'b0;

    //            use4  nld   ld     maxs   cyc  rsn   steps  q     ndr   dr
    vecs[0] = '{1'b0, 3'd3, 8'h16, 16'd0, 8'd8,  3'd2, 16'd3, 6'd1, 3'd1, 10'h001}; // 2 1 1
    vecs[1] = '{1'b0, 3'd3, 8'h14, 16'd0, 8'd1,  3'd1, 16'd0, 6'd3, 3'd3, 10'h014}; // 0 1 1 halt
    vecs[2] = '{1'b0, 3'd3, 8'h16, 16'd1, 8'd3,  3'd4, 16'd1, 6'd2, 3'd2, 10'h005}; // limit 1
    vecs[3] = '{1'b1, 3'd4, 8'h57, 16'd0, 8'd1,  3'd3, 16'd0, 6'd4, 3'd4, 10'h057}; // 3 1 1 1 ovfl
    vecs[4] = '{1'b0, 3'd3, 8'h0E, 16'd0, 8'd3,  3'd1, 16'd1, 6'd2, 3'd2, 10'h004}; // 2 3 0
    vecs[5] = '{1'b0, 3'd2, 8'h09, 16'd0, 8'd6,  3'd2, 16'd2, 6'd1, 3'd1, 10'h001}; // 1 2
    vecs[6] = '{1'b1, 3'd4, 8'h55, 16'd0, 8'd16, 3'd2, 16'd6, 6'd1, 3'd1, 10'h001}; // 1 1 1 1 wrap
    vecs[7] = '{1'b0, 3'd1, 8'h01, 16'd0, 8'd1,  3'd2, 16'd0, 6'd1, 3'd1, 10'h001}; // single 1
    vecs[8] = '{1'b0, 3'd2, 8'h09, 16'd2, 8'd6,  3'd4, 16'd2, 6'd1, 3'd1, 10'h001}; // limit beats short

    #1;
    check("rst_busy", int'(busy32), 0);
    check("rst_done", int'(done32), 0);
    tick; tick;
    rst = 1'b0;
    tick;
    check("rst_q", int'(q32), 0);
    check("rst_steps", int'(stp32), 0);
    check("rst_reason", int'(rsn32), 0);
    check("rst_ld_ready", int'(ldr32), 1);

    program_table;

    for (int i = 0; i < NVEC; i++) run_vec(vecs[i], i);

    // Still in DONE: start and table writes must both be ignored.
    use4 = 1'b0;
    start = 1'b1; tick; start = 1'b0;
    check("done_start_ignored_done", int'(s_done), 1);
    check("done_start_ignored_busy", int'(s_busy), 0);
    cfg_we = 1'b1; cfg_sym = 2'd2; cfg_len = 3'd0; cfg_word = 8'h00; tick; cfg_we = 1'b0;
    run_vec(vecs[5], 50);

    // Reset during the APPEND of step 2.
    load_and_start(vecs[0]);
    tick; tick; tick;
    check("mid_busy", int'(busy32), 1);
    check("mid_steps", int'(stp32), 2);
    rst = 1'b1; tick; rst = 1'b0;
    check("mrst_busy", int'(busy32), 0);
    check("mrst_done", int'(done32), 0);
    check("mrst_q", int'(q32), 0);
    check("mrst_steps", int'(stp32), 0);
    check("mrst_ld_ready", int'(ldr32), 1);
    tick;
    check("mrst_q_later", int'(q32), 0);
    program_table;

    // Fill to DEPTH plus one dropped push, then clear together with start.
    use4 = 1'b0;
    clear = 1'b1; tick; clear = 1'b0;
    for (int k = 0; k < 33; k++) begin
      ld_valid = 1'b1; ld_sym = 2'd1; tick;
    end
    ld_valid = 1'b0;
    check("full_q", int'(q32), 32);
    check("full_ld_ready", int'(ldr32), 0);
    clear = 1'b1; start = 1'b1; tick; clear = 1'b0; start = 1'b0;
    check("clr_q", int'(q32), 0);
    check("clr_busy", int'(busy32), 0);
    check("clr_ld_ready", int'(ldr32), 1);
    tick;
    check("clr_still_idle", int'(busy32), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
